// File: rtl/spi_transmitter.sv
// spi_transmitter: SPI master, WIDTH-bit MSB-first full-duplex words, SCK mode (CKP/CPH) chosen per word.
// Define SPI_BURST_EN to chain back-to-back words with SS held low while START stays high.
module spi_transmitter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             CKP,
  input  logic             CPH,
  input  logic [WIDTH-1:0] DATA_TX,
  input  logic             MISO,
  output logic             SCK,
  output logic             SS,
  output logic             MOSI,
  output logic [WIDTH-1:0] DATA_RX,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned EDGES  = 2 * WIDTH;
  localparam int unsigned EDGE_W = $clog2(EDGES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic              ckp_q, ckp_d;
  logic              cph_q, cph_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  data_rx_q, data_rx_d;
  logic              sck_q, sck_d;
  logic              ss_q, ss_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              div_last_c;
  logic              start_word_c;
  logic              edge_fire_c;
  logic [EDGE_W-1:0] edge_idx_c;

  assign div_last_c = (div_cnt_q == DIV_W'(DIV - 1));

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      ckp_q      <= 1'b0;
      cph_q      <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      data_rx_q  <= '0;
      sck_q      <= 1'b0;
      ss_q       <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ckp_q      <= ckp_d;
      cph_q      <= cph_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_rx_q  <= data_rx_d;
      sck_q      <= sck_d;
      ss_q       <= ss_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    ckp_d        = ckp_q;
    cph_d        = cph_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    data_rx_d    = data_rx_q;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    start_word_c = 1'b0;
    edge_fire_c  = 1'b0;
    edge_idx_c   = '0;

    case (state_q)
      IDLE: begin
        sck_d        = CKP;
        start_word_c = START;
      end

      SETUP: begin
        sck_d = ckp_q;
        if (div_last_c) begin
          state_d     = SHIFT;
          div_cnt_d   = '0;
          edge_fire_c = 1'b1;
          edge_idx_c  = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      SHIFT: begin
        if (div_last_c) begin
          div_cnt_d = '0;
          if (edge_cnt_q == EDGE_W'(EDGES - 1)) begin
            state_d = HOLD;
          end else begin
            edge_fire_c = 1'b1;
            edge_idx_c  = edge_cnt_q + EDGE_W'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      HOLD: begin
        sck_d = ckp_q;
        if (div_last_c) begin
          div_cnt_d = '0;
          state_d   = IDLE;
          ss_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          data_rx_d = rx_q;
`ifdef SPI_BURST_EN
          start_word_c = START;
`else
          start_word_c = 1'b0;
`endif
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Even edge index = leading edge; sample when parity matches CPH, otherwise drive
    if (edge_fire_c) begin
      sck_d      = ~sck_q;
      edge_cnt_d = edge_idx_c;
      if (edge_idx_c[0] == cph_q) begin
        rx_d = {rx_q[WIDTH-2:0], MISO};
      end else if (cph_q || (edge_idx_c != EDGE_W'(EDGES - 1))) begin
        mosi_d = tx_q[WIDTH-1];
        tx_d   = {tx_q[WIDTH-2:0], 1'b0};
      end
    end

    // Word launch: CPH=0 presents the MSB together with SS falling
    if (start_word_c) begin
      state_d   = SETUP;
      div_cnt_d = '0;
      ckp_d     = CKP;
      cph_d     = CPH;
      rx_d      = '0;
      ss_d      = 1'b0;
      busy_d    = 1'b1;
      sck_d     = CKP;
      if (!CPH) begin
        mosi_d = DATA_TX[WIDTH-1];
        tx_d   = {DATA_TX[WIDTH-2:0], 1'b0};
      end else begin
        tx_d = DATA_TX;
      end
    end
  end

  assign SCK     = sck_q;
  assign SS      = ss_q;
  assign MOSI    = mosi_q;
  assign DATA_RX = data_rx_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule
